// File: rtl/alu_ctrl_decode_stage_pkg.sv
// Shared ALU-control definitions: operation codes, opcode/funct7 constants and the
// registered entry layout used by the decode stage.
package alu_ctrl_decode_stage_pkg;

  typedef enum logic [4:0] {
    AluAdd    = 5'b00000,
    AluLui    = 5'b00001,
    AluSub    = 5'b00010,
    AluJalr   = 5'b00011,
    AluSltu   = 5'b00100,
    AluXor    = 5'b00101,
    AluOr     = 5'b00110,
    AluAnd    = 5'b00111,
    AluSll    = 5'b01000,
    AluSra    = 5'b01001,
    AluSrl    = 5'b01010,
    AluSlt    = 5'b01100,
    AluBeq    = 5'b01101,
    AluBge    = 5'b01110,
    AluBgeu   = 5'b01111,
    AluBlt    = 5'b10000,
    AluBltu   = 5'b10001,
    AluBne    = 5'b10010,
    AluMul    = 5'b10011,
    AluMulh   = 5'b10100,
    AluMulhsu = 5'b10101,
    AluMulhu  = 5'b10110,
    AluDiv    = 5'b10111,
    AluDivu   = 5'b11000,
    AluRem    = 5'b11001,
    AluRemu   = 5'b11010
  } alu_op_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7Muldiv = 7'b0000001;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    alu_op_e     alu_op;
    logic        is_branch;
    logic        illegal;
  } entry_t;

  // Control-transfer opcodes: conditional branches, JAL and JALR.
  function automatic logic is_branch_op(logic [6:0] opcode);
    return (opcode == OpBranch) || (opcode == OpJal) || (opcode == OpJalr);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_stage_if.sv
// Upstream/downstream handshake bundle of the ALU-control decode stage.
interface alu_ctrl_decode_stage_if #(
  parameter int unsigned CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [31:0]       in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic [CTRL_W-1:0] out_alu_ctrl;
  logic              out_is_branch;
  logic              out_illegal;

  // Driven by the environment around the stage (IFU side and EXU ready).
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_alu_ctrl, out_is_branch, out_illegal
  );

  // Seen from the decode stage itself.
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_alu_ctrl, out_is_branch, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode_stage_decode.sv
// Pure combinational RV32I(+M) decoder: instruction word -> ALU code, branch and illegal flags.
module alu_ctrl_decode_stage_decode
  import alu_ctrl_decode_stage_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] inst,
  output alu_op_e     alu_op,
  output logic        is_branch,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    op;
  logic       bad;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Opcode/funct decode; illegal encodings force the code back to ADD (all zero).
  always_comb begin
    op  = AluAdd;
    bad = 1'b0;
    case (opcode)
      OpLui:                             op = AluLui;
      OpAuipc, OpJal, OpFence, OpSystem: op = AluAdd;
      OpJalr:                            op = AluJalr;
      OpBranch: begin
        case (funct3)
          3'b000:  op = AluBeq;
          3'b001:  op = AluBne;
          3'b100:  op = AluBlt;
          3'b101:  op = AluBge;
          3'b110:  op = AluBltu;
          3'b111:  op = AluBgeu;
          default: bad = 1'b1;
        endcase
      end
      OpLoad:  bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OpStore: bad = (funct3 > 3'b010);
      OpImm: begin
        case (funct3)
          3'b000: op = AluAdd;
          3'b010: op = AluSlt;
          3'b011: op = AluSltu;
          3'b100: op = AluXor;
          3'b110: op = AluOr;
          3'b111: op = AluAnd;
          3'b001: begin
            op  = AluSll;
            bad = (funct7 != F7Base);
          end
          default: begin
            if (funct7 == F7Base)     op = AluSrl;
            else if (funct7 == F7Alt) op = AluSra;
            else                      bad = 1'b1;
          end
        endcase
      end
      OpReg: begin
        if (funct7 == F7Base) begin
          case (funct3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
          endcase
        end else if (funct7 == F7Alt) begin
          case (funct3)
            3'b000:  op = AluSub;
            3'b101:  op = AluSra;
            default: bad = 1'b1;
          endcase
        end else if ((funct7 == F7Muldiv) && EN_M) begin
          case (funct3)
            3'b000:  op = AluMul;
            3'b001:  op = AluMulh;
            3'b010:  op = AluMulhsu;
            3'b011:  op = AluMulhu;
            3'b100:  op = AluDiv;
            3'b101:  op = AluDivu;
            3'b110:  op = AluRem;
            default: op = AluRemu;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  assign alu_op    = bad ? AluAdd : op;
  assign illegal   = bad;
  assign is_branch = is_branch_op(opcode);

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// Registered ALU-control decode stage between IFU and EXU with valid/ready handshake,
// optional two-entry skid buffer and branch-redirect flush.
module alu_ctrl_decode_stage
  import alu_ctrl_decode_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = 5,
  parameter bit          EN_M   = 1'b0,
  parameter bit          SKID   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  alu_ctrl_decode_stage_if.slave bus
);

  alu_op_e dec_op;
  logic    dec_branch;
  logic    dec_illegal;
  entry_t  in_entry;
  entry_t  main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic    ready;
  logic    accept;
  logic    drain;

  alu_ctrl_decode_stage_decode #(
    .EN_M (EN_M)
  ) u_decode (
    .inst      (bus.in_inst),
    .alu_op    (dec_op),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  // Assemble the decoded entry that may be captured this cycle.
  always_comb begin
    in_entry           = '0;
    in_entry.inst      = bus.in_inst;
    in_entry.pc        = bus.in_pc;
    in_entry.alu_op    = dec_op;
    in_entry.is_branch = dec_branch;
    in_entry.illegal   = dec_illegal;
  end

  // Ready depends only on held state and reset, never on flush.
  assign ready  = SKID ? (!skid_valid_q && !rst) : ((!main_valid_q || bus.out_ready) && !rst);
  assign accept = bus.in_valid && ready && !flush;
  assign drain  = main_valid_q && bus.out_ready;

  // Next-state of main/skid registers: skid refills main first, main stays put while stalled.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept && SKID) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset clearing both valids and all data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready      = ready;
  assign bus.out_valid     = main_valid_q;
  assign bus.out_inst      = main_q.inst;
  assign bus.out_pc        = main_q.pc;
  assign bus.out_alu_ctrl  = CTRL_W'(main_q.alu_op);
  assign bus.out_is_branch = main_q.is_branch;
  assign bus.out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Bench for the ALU-control decode stage: an EN_M=1 and an EN_M=0 instance share one
// stimulus stream and are both compared against a queue-based reference model.
module tb_alu_ctrl_decode_stage;

  localparam int unsigned CW = 8;

  logic clk   = 1'b1;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_decode_stage_if #(.CTRL_W(CW)) bus_m ();
  alu_ctrl_decode_stage_if #(.CTRL_W(CW)) bus_n ();

  alu_ctrl_decode_stage #(.CTRL_W(CW), .EN_M(1'b1), .SKID(1'b1)) dut_m (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_m)
  );

  alu_ctrl_decode_stage #(.CTRL_W(CW), .EN_M(1'b0), .SKID(1'b1)) dut_n (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_n)
  );

  assign bus_n.in_valid  = bus_m.in_valid;
  assign bus_n.in_inst   = bus_m.in_inst;
  assign bus_n.in_pc     = bus_m.in_pc;
  assign bus_n.out_ready = bus_m.out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;

  txn_t model_q[$];

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                           7'h0f, 7'h73};

  // Reference decode from the instruction tables; returns {illegal, is_branch, code}.
  function automatic logic [6:0] ref_decode(logic [31:0] inst, bit en_m);
    int r_tab [8];
    int m_tab [8];
    int b_tab [8];
    int code;
    bit bad;
    bit br;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    r_tab = '{0, 8, 12, 4, 5, 10, 6, 7};
    m_tab = '{19, 20, 21, 22, 23, 24, 25, 26};
    b_tab = '{13, 18, -1, -1, 16, 14, 17, 15};
    opc  = inst[6:0];
    f3   = inst[14:12];
    f7   = inst[31:25];
    code = 0;
    bad  = 1'b0;
    case (opc)
      7'h37: code = 1;
      7'h17, 7'h6f, 7'h0f, 7'h73: code = 0;
      7'h67: code = 3;
      7'h63: begin
        code = b_tab[f3];
        bad  = (code < 0);
      end
      7'h03: bad = (f3 == 3'd3) || (f3 > 3'd5);
      7'h23: bad = (f3 > 3'd2);
      7'h13: begin
        code = r_tab[f3];
        if (f3 == 3'd1) bad = (f7 != 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) code = 9;
          else bad = (f7 != 7'h00);
        end
      end
      7'h33: begin
        if (f7 == 7'h00) code = r_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = 2;
        else if (f7 == 7'h20 && f3 == 3'd5) code = 9;
        else if (f7 == 7'h01 && en_m) code = m_tab[f3];
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    br = (opc == 7'h63) || (opc == 7'h6f) || (opc == 7'h67);
    if (bad) code = 0;
    return {bad, br, code[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs();
    chk("rst_inst_m", bus_m.out_inst, 32'h0);
    chk("rst_pc_m", bus_m.out_pc, 32'h0);
    chk("rst_ctrl_m", 32'(bus_m.out_alu_ctrl), 32'h0);
    chk("rst_br_m", 32'(bus_m.out_is_branch), 32'h0);
    chk("rst_ill_m", 32'(bus_m.out_illegal), 32'h0);
    chk("rst_inst_n", bus_n.out_inst, 32'h0);
    chk("rst_ctrl_n", 32'(bus_n.out_alu_ctrl), 32'h0);
  endtask

  task automatic check_outputs(input bit exp_rdy);
    logic [6:0] dm;
    logic [6:0] dn;
    chk("in_ready_m", 32'(bus_m.in_ready), 32'(exp_rdy));
    chk("in_ready_n", 32'(bus_n.in_ready), 32'(exp_rdy));
    chk("out_valid_m", 32'(bus_m.out_valid), 32'(model_q.size() > 0));
    chk("out_valid_n", 32'(bus_n.out_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      dm = ref_decode(model_q[0].inst, 1'b1);
      dn = ref_decode(model_q[0].inst, 1'b0);
      chk("inst_m", bus_m.out_inst, model_q[0].inst);
      chk("pc_m", bus_m.out_pc, model_q[0].pc);
      chk("ctrl_m", 32'(bus_m.out_alu_ctrl), 32'(dm[4:0]));
      chk("branch_m", 32'(bus_m.out_is_branch), 32'(dm[5]));
      chk("illegal_m", 32'(bus_m.out_illegal), 32'(dm[6]));
      chk("inst_n", bus_n.out_inst, model_q[0].inst);
      chk("ctrl_n", 32'(bus_n.out_alu_ctrl), 32'(dn[4:0]));
      chk("branch_n", 32'(bus_n.out_is_branch), 32'(dn[5]));
      chk("illegal_n", 32'(bus_n.out_illegal), 32'(dn[6]));
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit r);
    bit   exp_rdy;
    txn_t t;
    bus_m.in_valid  = v;
    bus_m.in_inst   = inst;
    bus_m.in_pc     = pc;
    bus_m.out_ready = ordy;
    flush           = fl;
    rst             = r;
    exp_rdy         = !r && (model_q.size() < 2);
    @(negedge clk);
    check_outputs(exp_rdy);
    @(posedge clk);
    if (r || fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
      if (v && exp_rdy) begin
        t.inst = inst;
        t.pc   = pc;
        model_q.push_back(t);
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] w;
    int          k;
    int          j;

    // Bring registers to a known state before any comparison.
    bus_m.in_valid  = 1'b0;
    bus_m.in_inst   = 32'h0;
    bus_m.in_pc     = 32'h0;
    bus_m.out_ready = 1'b0;
    @(posedge clk);
    #1;

    step(1'b1, 32'h00500093, 32'h50, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk_zero_outputs();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // addi, then sub/sltiu/slti back to back.
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h40208133, 32'h104, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0010B093, 32'h108, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0010A093, 32'h10c, 1'b1, 1'b0, 1'b0);

    // mul (legal only with EN_M) and an all-ones word.
    step(1'b1, 32'h022081B3, 32'h110, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 32'h114, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: third instruction must wait until the skid slot frees.
    step(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40208133, 32'h204, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0010B093, 32'h208, 1'b0, 1'b0, 1'b0);
    chk("stall_in_ready", 32'(bus_m.in_ready), 32'h0);
    step(1'b1, 32'h0010B093, 32'h208, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0010B093, 32'h208, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with two entries held and a new input offered.
    step(1'b1, 32'h00A00113, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00B00193, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00C00213, 32'h308, 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(bus_m.out_valid), 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset while two entries are held.
    step(1'b1, 32'h00A00113, 32'h400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00B00193, 32'h404, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00C00213, 32'h408, 1'b0, 1'b0, 1'b1);
    chk_zero_outputs();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic biased toward real opcodes and meaningful funct7 values.
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      k = $urandom_range(0, 11);
      if (k < 11) w[6:0] = ops[k];
      j = $urandom_range(0, 3);
      if (j == 0) w[31:25] = 7'h00;
      else if (j == 1) w[31:25] = 7'h20;
      else if (j == 2) w[31:25] = 7'h01;
      step($urandom_range(0, 9) < 7, w, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
